// File: rtl/alu_control_seq.sv
// EX-stage ALU control: combinational ALUOp/Funct decode plus a latency sequencer
// that stalls the pipeline while the external mul/div unit works.
module alu_control_seq #(
  parameter int OP_W    = 5,
  parameter int M_EXT   = 1,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             flush_i,
  input  logic [1:0]       ALUOp,
  input  logic             IsImm,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  output logic [OP_W-1:0]  Operation,
  output logic             illegal_o,
  output logic             stall_o,
  output logic             mop_start_o,
  output logic             mop_done_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_EQ     = 5'd10,
    OP_PASSB  = 5'd11,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  alu_op_e    base_op;
  alu_op_e    op_d;
  logic       illegal_d;
  logic       mop;
  logic       is_div;
  logic       start;
  logic [CW-1:0] lat_m1;

  seq_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          div_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Funct7=0 arithmetic, shared by R-type and I-type.
  always_comb begin
    base_op = OP_ADD;
    unique case (Funct3)
      3'b000: base_op = OP_ADD;
      3'b001: base_op = OP_SLL;
      3'b010: base_op = OP_SLT;
      3'b011: base_op = OP_SLTU;
      3'b100: base_op = OP_XOR;
      3'b101: base_op = OP_SRL;
      3'b110: base_op = OP_OR;
      3'b111: base_op = OP_AND;
      default: base_op = OP_ADD;
    endcase
  end

  always_comb begin
    op_d      = OP_ADD;
    illegal_d = 1'b0;
    unique case (ALUOp)
      2'b00: op_d = OP_ADD;
      2'b11: op_d = OP_PASSB;
      2'b01: begin
        unique case (Funct3[2:1])
          2'b00: op_d = OP_EQ;
          2'b01: begin
            op_d      = OP_EQ;
            illegal_d = 1'b1;
          end
          2'b10: op_d = OP_SLT;
          2'b11: op_d = OP_SLTU;
          default: op_d = OP_EQ;
        endcase
      end
      2'b10: begin
        if (IsImm) begin
          // Only shifts treat Funct7 as an opcode field; elsewhere it is immediate.
          if (Funct3 == 3'b001) begin
            if (Funct7 == F7_BASE) op_d = OP_SLL;
            else                   illegal_d = 1'b1;
          end else if (Funct3 == 3'b101) begin
            if (Funct7 == F7_BASE)     op_d = OP_SRL;
            else if (Funct7 == F7_ALT) op_d = OP_SRA;
            else                       illegal_d = 1'b1;
          end else begin
            op_d = base_op;
          end
        end else begin
          unique case (Funct7)
            F7_BASE: op_d = base_op;
            F7_ALT: begin
              if (Funct3 == 3'b000)      op_d = OP_SUB;
              else if (Funct3 == 3'b101) op_d = OP_SRA;
              else                       illegal_d = 1'b1;
            end
            F7_MEXT: begin
              if (M_EXT != 0) op_d = alu_op_e'({2'b10, Funct3});
              else            illegal_d = 1'b1;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      default: op_d = OP_ADD;
    endcase
  end

  assign Operation = OP_W'(op_d);
  assign illegal_o = illegal_d;

  assign mop    = valid_i & (op_d >= OP_MUL) & ~illegal_d;
  assign is_div = op_d[2];
  assign lat_m1 = is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
  assign start  = rst_n & (state_q == S_IDLE) & mop & ~flush_i;

  // Flush drops the stall and cancels completion in the same cycle.
  assign mop_start_o = start;
  assign stall_o     = start | ((state_q == S_BUSY) & ~flush_i);
  assign mop_done_o  = (state_q == S_DONE) & ~flush_i;
  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_BUSY;
            cnt_q   <= lat_m1;
            div_q   <= is_div;
          end
        end
        S_BUSY: begin
          if (flush_i)            state_q <= S_IDLE;
          else if (cnt_q == '0)   state_q <= S_DONE;
          else                    cnt_q   <= cnt_q - CW'(1);
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && (state_q == S_BUSY)) begin
      assert (cnt_q <= (div_q ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1)));
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: spec-level decode model and a remaining-cycles
// sequencer model, driven by directed scenarios and $urandom traffic.
module tb_alu_control_seq;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       valid_i;
  logic       valid_nm;
  logic       flush_i;
  logic [1:0] ALUOp;
  logic       IsImm;
  logic [6:0] Funct7;
  logic [2:0] Funct3;

  logic [7:0]  op_a;
  logic        ill_a, stall_a, start_a, done_a;
  logic [31:0] cnt_a;
  logic [4:0]  op_b;
  logic        ill_b, stall_b, start_b, done_b;
  logic [31:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_left = 0;
  int          m_nxt  = 0;
  int unsigned m_cnt  = 0;

  alu_control_seq #(.OP_W(8), .M_EXT(1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .IsImm(IsImm), .Funct7(Funct7), .Funct3(Funct3),
    .Operation(op_a), .illegal_o(ill_a), .stall_o(stall_a),
    .mop_start_o(start_a), .mop_done_o(done_a), .stall_cnt_o(cnt_a)
  );

  alu_control_seq #(.OP_W(5), .M_EXT(0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(32)) dut_nm (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_nm), .flush_i(flush_i),
    .ALUOp(ALUOp), .IsImm(IsImm), .Funct7(Funct7), .Funct3(Funct3),
    .Operation(op_b), .illegal_o(ill_b), .stall_o(stall_b),
    .mop_start_o(start_b), .mop_done_o(done_b), .stall_cnt_o(cnt_b)
  );

  // Returns {illegal, op[4:0]} straight from the decode rules.
  function automatic logic [5:0] ref_decode(input logic [1:0] aop, input logic imm,
                                            input logic [6:0] f7, input logic [2:0] f3,
                                            input bit mext);
    int base [8];
    int op;
    bit ill;
    base = '{0, 5, 8, 9, 4, 6, 3, 2};
    op   = 0;
    ill  = 0;
    case (aop)
      2'b00: op = 0;
      2'b11: op = 11;
      2'b01: begin
        op  = (f3 >= 6) ? 9 : (f3 >= 4) ? 8 : 10;
        ill = (f3 == 2 || f3 == 3);
      end
      default: begin
        if (imm) begin
          if (f3 == 1 || f3 == 5) begin
            if (f7 == 0)                     op = base[f3];
            else if (f3 == 5 && f7 == 7'h20) op = 7;
            else                             ill = 1;
          end else begin
            op = base[f3];
          end
        end else if (f7 == 0)                 op = base[f3];
        else if (f7 == 7'h20 && f3 == 0)      op = 1;
        else if (f7 == 7'h20 && f3 == 5)      op = 7;
        else if (f7 == 7'h01 && mext)         op = 16 + int'(f3);
        else                                  ill = 1;
      end
    endcase
    return {ill, 5'(op)};
  endfunction

  task automatic drive(input logic v, input logic fl, input logic [1:0] aop,
                       input logic imm, input logic [6:0] f7, input logic [2:0] f3);
    valid_i = v;
    flush_i = fl;
    ALUOp   = aop;
    IsImm   = imm;
    Funct7  = f7;
    Funct3  = f3;
  endtask

  // Remaining-cycles model: m_left counts stall cycles plus the done cycle still ahead.
  task automatic model_cycle(output bit e_start, output bit e_stall, output bit e_done);
    logic [5:0] d;
    bit mop;
    d = ref_decode(ALUOp, IsImm, Funct7, Funct3, 1'b1);
    mop = valid_i && !d[5] && (d[4:0] >= 5'd16);
    e_start = 0; e_stall = 0; e_done = 0;
    m_nxt = m_left;
    if (m_left == 0) begin
      if (mop && !flush_i) begin
        e_start = 1;
        e_stall = 1;
        m_nxt   = ((d[4:0] >= 5'd20) ? DIV_LAT : MUL_LAT) + 1;
      end
    end else if (m_left == 1) begin
      e_done = !flush_i;
      m_nxt  = 0;
    end else begin
      e_stall = !flush_i;
      m_nxt   = flush_i ? 0 : m_left - 1;
    end
    if (e_stall) m_cnt = m_cnt + 1;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    valid_nm = 1'b0;
    drive(0, 0, 2'b00, 0, 7'h00, 3'b000);
    #12;
    n_checks++;
    if ({stall_a, start_a, done_a, cnt_a} !== 35'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got stall=%b start=%b done=%b cnt=%0d expected all zero",
               stall_a, start_a, done_a, cnt_a);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    m_left = 0;
    m_cnt  = 0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({stall_a, cnt_a} !== 33'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got stall=%b cnt=%0d expected 0/0", stall_a, cnt_a);
    end
  endtask

  task automatic test_decode_directed;
    logic [1:0] aops [6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b11};
    logic       imms [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [6:0] f7s  [6] = '{7'h00, 7'h00, 7'h20, 7'h00, 7'h7f, 7'h00};
    logic [2:0] f3s  [6] = '{3'b001, 3'b100, 3'b000, 3'b110, 3'b000, 3'b000};
    logic [7:0] exp_op  [6] = '{8'd5, 8'd4, 8'd1, 8'd9, 8'd0, 8'd11};
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, aops[i], imms[i], f7s[i], f3s[i]);
      #1;
      n_checks++;
      if ({op_a, ill_a} !== {exp_op[i], 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL decode_directed[%0d]: got op=%0d ill=%b expected op=%0d ill=0",
                 i, op_a, ill_a, exp_op[i]);
      end
    end
    drive(0, 0, 2'b01, 0, 7'h00, 3'b011);
    #1;
    n_checks++;
    if ({op_a, ill_a} !== {8'd10, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL decode_branch_illegal: got op=%0d ill=%b expected op=10 ill=1", op_a, ill_a);
    end
  endtask

  task automatic test_decode_random;
    logic [5:0] ea, eb;
    logic [6:0] f7pick [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
    for (int i = 0; i < 300; i++) begin
      f7pick[3] = 7'($urandom);
      drive(0, 0, 2'($urandom), 1'($urandom), f7pick[$urandom_range(0, 3)], 3'($urandom));
      #2;
      ea = ref_decode(ALUOp, IsImm, Funct7, Funct3, 1'b1);
      eb = ref_decode(ALUOp, IsImm, Funct7, Funct3, 1'b0);
      n_checks++;
      if ({ill_a, op_a, stall_a} !== {ea[5], 3'b000, ea[4:0], 1'b0}) begin
        n_fail++;
        $display("[TB] FAIL decode_rand_mext: aop=%b imm=%b f7=%h f3=%b got op=%0d ill=%b stall=%b expected op=%0d ill=%b stall=0",
                 ALUOp, IsImm, Funct7, Funct3, op_a, ill_a, stall_a, ea[4:0], ea[5]);
      end
      n_checks++;
      if ({ill_b, op_b} !== eb) begin
        n_fail++;
        $display("[TB] FAIL decode_rand_nomext: aop=%b imm=%b f7=%h f3=%b got op=%0d ill=%b expected op=%0d ill=%b",
                 ALUOp, IsImm, Funct7, Funct3, op_b, ill_b, eb[4:0], eb[5]);
      end
    end
  endtask

  task automatic test_mext_off;
    @(negedge clk);
    drive(0, 0, 2'b10, 0, 7'h01, 3'b000);
    valid_nm = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if ({op_b, ill_b, stall_b, start_b, done_b, cnt_b} !== {5'd0, 1'b1, 3'b000, 32'd0}) begin
        n_fail++;
        $display("[TB] FAIL mext_off[%0d]: got op=%0d ill=%b stall=%b start=%b done=%b cnt=%0d expected op=0 ill=1 others 0",
                 c, op_b, ill_b, stall_b, start_b, done_b, cnt_b);
      end
      @(negedge clk);
    end
    valid_nm = 1'b0;
  endtask

  task automatic test_mul;
    bit es, est, ed;
    int unsigned base;
    base = m_cnt;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(c < 5, 0, 2'b10, 0, 7'h01, 3'b000);
      #1;
      model_cycle(es, est, ed);
      n_checks++;
      if ({start_a, stall_a, done_a} !== {c == 0, c <= 3, c == 4}) begin
        n_fail++;
        $display("[TB] FAIL mul_cycle%0d: got start=%b stall=%b done=%b expected %b%b%b",
                 c, start_a, stall_a, done_a, c == 0, c <= 3, c == 4);
      end
      @(posedge clk);
      m_left = m_nxt;
    end
    @(negedge clk);
    drive(0, 0, 2'b00, 0, 7'h00, 3'b000);
    #1;
    n_checks++;
    if (cnt_a !== base + 4) begin
      n_fail++;
      $display("[TB] FAIL mul_stall_count: got %0d expected %0d", cnt_a, base + 4);
    end
  endtask

  task automatic test_back_to_back;
    bit es, est, ed;
    int t;
    int unsigned base;
    base = m_cnt;
    for (int c = 0; c < 71; c++) begin
      @(negedge clk);
      drive(c < 70, 0, 2'b10, 0, 7'h01, (c < 35) ? 3'b101 : 3'b110);
      #1;
      model_cycle(es, est, ed);
      t = (c < 35) ? c : c - 35;
      n_checks++;
      if ({start_a, stall_a, done_a} !== {t == 0 && c < 70, t <= 33 && c < 70, t == 34}) begin
        n_fail++;
        $display("[TB] FAIL divu_rem_cycle%0d: got start=%b stall=%b done=%b expected %b%b%b",
                 c, start_a, stall_a, done_a, t == 0 && c < 70, t <= 33 && c < 70, t == 34);
      end
      @(posedge clk);
      m_left = m_nxt;
    end
    @(negedge clk);
    drive(0, 0, 2'b00, 0, 7'h00, 3'b000);
    #1;
    n_checks++;
    if (cnt_a !== base + 68) begin
      n_fail++;
      $display("[TB] FAIL divu_rem_stall_count: got %0d expected %0d", cnt_a, base + 68);
    end
  endtask

  task automatic test_flush;
    bit es, est, ed;
    bit xs, xst, xd;
    int unsigned base;
    base = m_cnt;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      drive(c < 14, (c == 2) || (c == 8), 2'b10, 0, 7'h01, (c < 3) ? 3'b100 : 3'b000);
      #1;
      model_cycle(es, est, ed);
      xs  = (c == 0) || (c == 3) || (c == 9);
      xst = c inside {0, 1, 3, 4, 5, 6, 9, 10, 11, 12};
      xd  = (c == 7) || (c == 13);
      n_checks++;
      if ({start_a, stall_a, done_a} !== {xs, xst, xd}) begin
        n_fail++;
        $display("[TB] FAIL flush_cycle%0d: got start=%b stall=%b done=%b expected %b%b%b",
                 c, start_a, stall_a, done_a, xs, xst, xd);
      end
      @(posedge clk);
      m_left = m_nxt;
    end
    @(negedge clk);
    drive(0, 0, 2'b00, 0, 7'h00, 3'b000);
    #1;
    n_checks++;
    if (cnt_a !== base + 10) begin
      n_fail++;
      $display("[TB] FAIL flush_stall_count: got %0d expected %0d", cnt_a, base + 10);
    end
  endtask

  task automatic test_random_mops;
    bit es, est, ed;
    logic [5:0] d;
    logic [6:0] f7pick [4] = '{7'h01, 7'h01, 7'h00, 7'h20};
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      drive(($urandom % 4) != 0, ($urandom % 12) == 0,
            (($urandom % 4) != 0) ? 2'b10 : 2'($urandom), ($urandom % 5) == 0,
            f7pick[$urandom_range(0, 3)], 3'($urandom));
      #1;
      d = ref_decode(ALUOp, IsImm, Funct7, Funct3, 1'b1);
      n_checks++;
      if ({cnt_a, ill_a, op_a} !== {m_cnt, d[5], 3'b000, d[4:0]}) begin
        n_fail++;
        $display("[TB] FAIL rand_decode_cnt@%0d: got cnt=%0d ill=%b op=%0d expected cnt=%0d ill=%b op=%0d",
                 c, cnt_a, ill_a, op_a, m_cnt, d[5], d[4:0]);
      end
      model_cycle(es, est, ed);
      n_checks++;
      if ({start_a, stall_a, done_a} !== {es, est, ed}) begin
        n_fail++;
        $display("[TB] FAIL rand_seq@%0d: got start=%b stall=%b done=%b expected %b%b%b",
                 c, start_a, stall_a, done_a, es, est, ed);
      end
      @(posedge clk);
      m_left = m_nxt;
    end
    // Let any op still in flight drain so later tests begin idle.
    for (int c = 0; c < DIV_LAT + 3; c++) begin
      @(negedge clk);
      drive(0, 0, 2'b00, 0, 7'h00, 3'b000);
      #1;
      model_cycle(es, est, ed);
      @(posedge clk);
      m_left = m_nxt;
    end
  endtask

  task automatic test_async_reset;
    bit es, est, ed;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1, 0, 2'b10, 0, 7'h01, 3'b100);
      #1;
      model_cycle(es, est, ed);
      @(posedge clk);
      m_left = m_nxt;
    end
    @(negedge clk);
    #2;
    n_checks++;
    if (stall_a !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL busy_before_reset: got stall=%b expected 1", stall_a);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stall_a, start_a, done_a, cnt_a} !== 35'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got stall=%b start=%b done=%b cnt=%0d expected all zero",
               stall_a, start_a, done_a, cnt_a);
    end
    valid_i = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    m_left = 0;
    m_cnt  = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if ({stall_a, start_a, done_a, cnt_a} !== 35'd0) begin
        n_fail++;
        $display("[TB] FAIL post_reset_idle%0d: got stall=%b start=%b done=%b cnt=%0d expected all zero",
                 c, stall_a, start_a, done_a, cnt_a);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_decode_directed();
    test_decode_random();
    test_mext_off();
    test_mul();
    test_back_to_back();
    test_flush();
    test_random_mops();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
